// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg
//   Shared types and sizing helpers for the idle-detect clock-gating controller.
//   - cg_state_e   : per-domain FSM state (RUN / OFF / WAKE)
//   - WAKE_CNT_W   : settle counter width for the default WAKE_CYCLES
//   - wake_cnt_w() : settle counter width for an arbitrary WAKE_CYCLES
package clk_gate_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } cg_state_e;

  localparam int WAKE_CYCLES_DEF = 2;
  localparam int WAKE_CNT_W      = $clog2(WAKE_CYCLES_DEF + 1);

  // The width must hold the count 0..cycles-1; never narrower than one bit.
  function automatic int wake_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clk_gate_domain_fsm.sv
// clk_gate_domain_fsm
//   One domain's gating FSM: counts idle cycles in RUN, gates off at the
//   programmed threshold, re-enables on demand and holds a settle window
//   before reporting ready.
// Ports:
//   i_clock       ungated source clock
//   i_reset       synchronous active-high reset
//   i_wake        busy | force_on for this domain
//   i_idle_thresh idle cycles before gating; 0 disables gating
//   i_scan_mode   forces RUN and clears counters while high
//   o_cg_en       registered ICG enable
//   o_ready       registered "clock running and settled"
//   o_cg_en_nxt   value o_cg_en takes at the next edge (for the top's AND-reduce)
module clk_gate_domain_fsm
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wake,
  input  logic [IDLE_W-1:0] i_idle_thresh,
  input  logic              i_scan_mode,
  output logic              o_cg_en,
  output logic              o_ready,
  output logic              o_cg_en_nxt
);

  localparam int                WCW       = wake_cnt_w(WAKE_CYCLES);
  localparam logic [WCW-1:0]    WAKE_LAST = WCW'(WAKE_CYCLES - 1);
  localparam logic [WCW-1:0]    WAKE_ONE  = WCW'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  cg_state_e         r_state, w_state_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [WCW-1:0]    r_wake_cnt, w_wake_cnt_nxt;
  logic              r_cg_en, r_ready;
  logic              w_cg_en_nxt, w_ready_nxt;
  logic              w_thresh_hit;

  // >= rather than == so a threshold lowered mid-count takes effect on the
  // next idle cycle instead of waiting for a wrap.
  assign w_thresh_hit = (i_idle_thresh != '0) &&
                        (r_idle_cnt >= (i_idle_thresh - IDLE_ONE));

  // State and counter registers; outputs registered so the ICG E pin never
  // sees decode glitches.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_cg_en    <= 1'b1;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_cg_en    <= w_cg_en_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    if (i_scan_mode) begin
      w_state_nxt    = RUN;
      w_idle_cnt_nxt = '0;
      w_wake_cnt_nxt = '0;
    end else begin
      case (r_state)
        RUN: begin
          // Wake wins over an expiring threshold on the same cycle.
          if (i_wake) begin
            w_idle_cnt_nxt = '0;
          end else if (w_thresh_hit) begin
            w_state_nxt    = OFF;
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_cnt_nxt = r_idle_cnt + IDLE_ONE;
          end
        end
        OFF: begin
          if (i_wake) begin
            w_state_nxt    = WAKE;
            w_wake_cnt_nxt = '0;
          end
        end
        WAKE: begin
          // Settle window runs to completion regardless of i_wake.
          if (r_wake_cnt == WAKE_LAST) begin
            w_state_nxt    = RUN;
            w_wake_cnt_nxt = '0;
            w_idle_cnt_nxt = '0;
          end else begin
            w_wake_cnt_nxt = r_wake_cnt + WAKE_ONE;
          end
        end
        default: begin
          w_state_nxt    = RUN;
          w_idle_cnt_nxt = '0;
          w_wake_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, captured by the output registers.
  always_comb begin
    w_cg_en_nxt = (w_state_nxt != OFF);
    w_ready_nxt = (w_state_nxt == RUN);
  end

  assign o_cg_en     = r_cg_en;
  assign o_ready     = r_ready;
  assign o_cg_en_nxt = w_cg_en_nxt;

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Idle-detect clock-gating controller driving E/TE of one ICG per domain.
// Ports:
//   clock        ungated source clock (ICG CP)
//   reset        synchronous active-high reset
//   busy         per-domain pending work
//   force_on     per-domain software override
//   idle_thresh  idle cycles before gating; 0 disables gating
//   scan_mode    DFT mode
//   cg_en        per-domain ICG E, registered
//   cg_te        shared ICG TE, follows scan_mode combinationally
//   ready        per-domain running-and-settled, registered
//   all_gated    every domain gated, registered alongside cg_en
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_DOMAINS-1:0] busy,
  input  logic [NUM_DOMAINS-1:0] force_on,
  input  logic [IDLE_W-1:0]      idle_thresh,
  input  logic                   scan_mode,
  output logic [NUM_DOMAINS-1:0] cg_en,
  output logic                   cg_te,
  output logic [NUM_DOMAINS-1:0] ready,
  output logic                   all_gated
);

  logic [NUM_DOMAINS-1:0] w_wake;
  logic [NUM_DOMAINS-1:0] w_cg_en_nxt;
  logic                   r_all_gated;

  assign w_wake = busy | force_on;

  generate
    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
      clk_gate_domain_fsm #(
        .IDLE_W      (IDLE_W),
        .WAKE_CYCLES (WAKE_CYCLES)
      ) u_fsm (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_wake        (w_wake[g]),
        .i_idle_thresh (idle_thresh),
        .i_scan_mode   (scan_mode),
        .o_cg_en       (cg_en[g]),
        .o_ready       (ready[g]),
        .o_cg_en_nxt   (w_cg_en_nxt[g])
      );
    end
  endgenerate

  assign cg_te = scan_mode;

  // Reduced from the next-state enables so it lands on the same edge as cg_en.
  always_ff @(posedge clock) begin
    if (reset) r_all_gated <= 1'b0;
    else       r_all_gated <= ~|w_cg_en_nxt;
  end

  assign all_gated = r_all_gated;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  localparam int ND = 4;
  localparam int IW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [ND-1:0] busy, force_on;
  logic [IW-1:0] idle_thresh;
  logic          scan_mode;
  logic [ND-1:0] cg_en, ready;
  logic          cg_te, all_gated;

  typedef struct packed {
    logic [ND-1:0] en;
    logic [ND-1:0] rdy;
    logic          ag;
    logic          te;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  clk_gate_ctrl #(.NUM_DOMAINS(ND), .IDLE_W(IW), .WAKE_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .busy        (busy),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
    .scan_mode   (scan_mode),
    .cg_en       (cg_en),
    .cg_te       (cg_te),
    .ready       (ready),
    .all_gated   (all_gated)
  );

  always #5 clock = ~clock;

  // One cycle: drive inputs on the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic cyc(input logic rst, input logic [ND-1:0] b, input logic [ND-1:0] f,
                     input logic [IW-1:0] th, input logic sc,
                     input logic [ND-1:0] en, input logic [ND-1:0] rdy,
                     input logic ag, input string nm);
    exp_t e;
    @(negedge clock);
    reset       = rst;
    busy        = b;
    force_on    = f;
    idle_thresh = th;
    scan_mode   = sc;
    e.en  = en;
    e.rdy = rdy;
    e.ag  = ag;
    e.te  = sc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one output sample per cycle, compared against the scoreboard.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if ({cg_en, ready, all_gated, cg_te} !== {e.en, e.rdy, e.ag, e.te}) begin
          n_fail++;
          $display("FAIL %s: got en=%h rdy=%h ag=%b te=%b, want en=%h rdy=%h ag=%b te=%b",
                   nm, cg_en, ready, all_gated, cg_te, e.en, e.rdy, e.ag, e.te);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; busy = '0; force_on = '0; idle_thresh = 8'd4; scan_mode = 1'b0;

    // Reset state
    cyc(1, 0, 0, 4, 0, 4'hF, 4'hF, 0, "reset");
    cyc(1, 0, 0, 4, 0, 4'hF, 4'hF, 0, "reset");

    // Gate-off after 4 idle edges
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4, 0, 4'hF, 4'hF, 0, "idle_run");
    cyc(0, 0, 0, 4, 0, 4'h0, 4'h0, 1, "gate_off");
    cyc(0, 0, 0, 4, 0, 4'h0, 4'h0, 1, "stay_off");

    // One-cycle busy pulse on domain 2: enable next edge, ready two later
    cyc(0, 4'h4, 0, 4, 0, 4'h4, 4'h0, 0, "wake_en");
    cyc(0, 0,    0, 4, 0, 4'h4, 4'h0, 0, "wake_settle");
    cyc(0, 0,    0, 4, 0, 4'h4, 4'h4, 0, "wake_ready");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4, 0, 4'h4, 4'h4, 0, "regate_count");
    cyc(0, 0, 0, 4, 0, 4'h0, 4'h0, 1, "regate_off");

    // Busy exactly on the threshold cycle: stays on, count restarts
    cyc(0, 4'hF, 0, 4, 0, 4'hF, 4'h0, 0, "wake_all");
    cyc(0, 0,    0, 4, 0, 4'hF, 4'h0, 0, "wake_all_settle");
    cyc(0, 0,    0, 4, 0, 4'hF, 4'hF, 0, "wake_all_ready");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4, 0, 4'hF, 4'hF, 0, "idle_pre");
    cyc(0, 4'hF, 0, 4, 0, 4'hF, 4'hF, 0, "wake_on_thresh");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4, 0, 4'hF, 4'hF, 0, "restart_count");
    cyc(0, 0, 0, 4, 0, 4'h0, 4'h0, 1, "gate_after_restart");

    // Threshold 0: OFF domains stay OFF, RUN domains never gate
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, "off_thresh0");
    cyc(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 0, "wake_t0");
    cyc(0, 0,    0, 0, 0, 4'hF, 4'h0, 0, "wake_t0_settle");
    cyc(0, 0,    0, 0, 0, 4'hF, 4'hF, 0, "ready_t0");
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, "thresh0_hold");

    // Saturated counter (255, a wrap would leave 44) gates at once against 60;
    // force_on keeps domain 1 running
    cyc(0, 0, 4'h2, 60, 0, 4'h2, 4'h2, 0, "sat_gate");
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h2, 3, 0, 4'h2, 4'h2, 0, "force_hold");
    cyc(0, 0, 0, 3, 0, 4'h2, 4'h2, 0, "force_rel");
    cyc(0, 0, 0, 3, 0, 4'h2, 4'h2, 0, "force_rel");
    cyc(0, 0, 0, 3, 0, 4'h0, 4'h0, 1, "force_rel_off");

    // Scan mode while domains are OFF / WAKE
    cyc(0, 4'h1, 0, 3, 0, 4'h1, 4'h0, 0, "wake_d0");
    cyc(0, 0,    0, 3, 1, 4'hF, 4'hF, 0, "scan_on");
    cyc(0, 0,    0, 3, 1, 4'hF, 4'hF, 0, "scan_hold");
    cyc(0, 0,    0, 3, 1, 4'hF, 4'hF, 0, "scan_hold");
    cyc(0, 0,    0, 3, 0, 4'hF, 4'hF, 0, "scan_rel");
    cyc(0, 0,    0, 3, 0, 4'hF, 4'hF, 0, "scan_rel");
    cyc(0, 0,    0, 3, 0, 4'h0, 4'h0, 1, "scan_rel_off");

    // Reset mid-WAKE and from OFF
    cyc(0, 4'hF, 0, 3, 0, 4'hF, 4'h0, 0, "wake_pre_rst");
    cyc(1, 0,    0, 3, 0, 4'hF, 4'hF, 0, "rst_mid_wake");
    cyc(0, 0,    0, 3, 0, 4'hF, 4'hF, 0, "post_rst");
    cyc(0, 0,    0, 3, 0, 4'hF, 4'hF, 0, "post_rst");
    cyc(0, 0,    0, 3, 0, 4'h0, 4'h0, 1, "post_rst_off");
    cyc(1, 0,    0, 3, 0, 4'hF, 4'hF, 0, "rst_from_off");

    // Threshold 1 gates on the first idle edge
    cyc(0, 0, 0, 1, 0, 4'h0, 4'h0, 1, "thresh1_gate");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
